ad_ave: RTL



---
 rtl/ad_ave_pkg.sv | 18 +
 rtl/ad_ave_ch.sv | 39 +++
 rtl/ad_ave.sv | 86 ++++++++
 3 files changed

// File: rtl/ad_ave_pkg.sv
// Shared constants and state encoding for the two-channel ADC averager.
package ad_ave_pkg;

  localparam int DW    = 16;
  localparam int K_MAX = 8;
  localparam int ACC_W = DW + K_MAX;
  localparam int KW    = 4;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  function automatic logic [KW-1:0] clamp_k(input logic [3:0] cfg);
    return (cfg > KW'(K_MAX)) ? KW'(K_MAX) : cfg;
  endfunction

endpackage

// File: rtl/ad_ave_ch.sv
// One averaging channel: running accumulator and the rounded-mean output register.
module ad_ave_ch
  import ad_ave_pkg::*;
(
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          add,
  input  logic          close,
  input  logic [KW-1:0] k_out,
  input  logic [DW-1:0] smp,
  output logic [DW-1:0] stu_data
);

  localparam int SW = ACC_W + 1;

  logic [ACC_W-1:0] acc;
  logic [SW-1:0]    rnd;
  logic [SW-1:0]    sum_rnd;

  // The closing sample is folded in combinationally so the mean lands one cycle after it.
  always_comb begin
    rnd = '0;
    if (k_out != '0) rnd = SW'(1) << (k_out - KW'(1));
    sum_rnd = SW'(acc) + SW'(smp) + rnd;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      stu_data <= '0;
    end else begin
      if (clr || close) acc <= '0;
      else if (add)     acc <= acc + ACC_W'(smp);
      if (close) stu_data <= DW'(sum_rnd >> k_out);
    end
  end

endmodule

// File: rtl/ad_ave.sv
// Two-channel ADC averager: windows of 2^k samples, publishes rounded means with a strobe.
//   state | meaning
//   IDLE  | averaging disabled, accumulators held at zero
//   ACC   | collecting samples of the current window
module ad_ave
  import ad_ave_pkg::*;
(
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          ave_en,
  input  logic [7:0]    cfg_ave,
  input  logic          ad_vld,
  input  logic [DW-1:0] ad_s1,
  input  logic [DW-1:0] ad_s2,
  output logic [DW-1:0] stu_data_s1,
  output logic [DW-1:0] stu_data_s2,
  output logic          ave_vld,
  output logic [15:0]   ave_cnt
);

  localparam int CW = K_MAX + 1;

  state_t         state, state_nxt;
  logic [KW-1:0]  k_win, k_eff;
  logic [K_MAX-1:0] smp_cnt;
  logic           last, close, add, clr, start;
  logic           cfg_unused;

  assign cfg_unused = ^cfg_ave[7:4];
  assign k_eff      = clamp_k(cfg_ave[3:0]);
  assign last       = ({1'b0, smp_cnt} == ((CW'(1) << k_win) - CW'(1)));
  // A closing sample completes its window even if ave_en drops in the same cycle.
  assign close      = (state == ACC) && ad_vld && last;
  assign add        = (state == ACC) && ad_vld && ave_en && !last;
  assign clr        = (state == IDLE) || !ave_en;
  assign start      = (state == IDLE) && ave_en;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ave_en)  state_nxt = ACC;
      ACC:     if (!ave_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      k_win   <= '0;
      smp_cnt <= '0;
      ave_vld <= 1'b0;
      ave_cnt <= '0;
    end else begin
      state   <= state_nxt;
      ave_vld <= close;
      if (start || close) k_win <= k_eff;
      if (clr || close)   smp_cnt <= '0;
      else if (add)       smp_cnt <= smp_cnt + 1'b1;
      if (close)          ave_cnt <= ave_cnt + 16'd1;
    end
  end

  ad_ave_ch u_ch1 (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .clr      (clr),
    .add      (add),
    .close    (close),
    .k_out    (k_win),
    .smp      (ad_s1),
    .stu_data (stu_data_s1)
  );

  ad_ave_ch u_ch2 (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .clr      (clr),
    .add      (add),
    .close    (close),
    .k_out    (k_win),
    .smp      (ad_s2),
    .stu_data (stu_data_s2)
  );

endmodule
